// File: rtl/alu_op_sequencer.sv
// ALU front-end sequencer: accepts a request, pulses one unit enable for a cycle, then captures that unit's result.
// Build option ALU_SEQ_PIPE_EN: a response retire and the next request accept may share one edge (RESP -> ISSUE).
module alu_op_sequencer #(
  parameter int OPERAND_WIDTH = 16,
  parameter int FUN_WIDTH     = 4,
  parameter int OUT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_seq,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [OPERAND_WIDTH-1:0] req_a,
  input  logic [OPERAND_WIDTH-1:0] req_b,
  input  logic [FUN_WIDTH-1:0]     req_fun,
  output logic [OPERAND_WIDTH-1:0] a_unit,
  output logic [OPERAND_WIDTH-1:0] b_unit,
  output logic [1:0]               fun_unit,
  output logic                     arith_enable,
  output logic                     logic_enable,
  output logic                     cmp_enable,
  output logic                     shift_enable,
  input  logic [OUT_WIDTH-1:0]     arith_out,
  input  logic [OUT_WIDTH-1:0]     logic_out,
  input  logic [OUT_WIDTH-1:0]     cmp_out,
  input  logic [OUT_WIDTH-1:0]     shift_out,
  input  logic                     arith_flag,
  input  logic                     logic_flag,
  input  logic                     cmp_flag,
  input  logic                     shift_flag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [OUT_WIDTH-1:0]     rsp_data,
  output logic                     rsp_flag,
  output logic [1:0]               rsp_unit
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    RESP    = 2'b11
  } state_t;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  state_t                   state_r;
  state_t                   state_s;
  logic                     ready_r;
  logic                     req_ready_s;
  logic                     accept_s;
  logic [1:0]               unit_r;
  logic [1:0]               fun_r;
  logic [OPERAND_WIDTH-1:0] a_r;
  logic [OPERAND_WIDTH-1:0] b_r;
  logic [3:0]               en_s;
  logic                     sel_flag_s;
  logic [OUT_WIDTH-1:0]     sel_out_s;
  logic                     rsp_valid_r;
  logic [OUT_WIDTH-1:0]     rsp_data_r;
  logic                     rsp_flag_r;
  logic [1:0]               rsp_unit_r;

  // Request readiness: a registered IDLE indication, extended in RESP when pipelining is built in.
  always_comb begin
    req_ready_s = ready_r;
`ifdef ALU_SEQ_PIPE_EN
    if (state_r == RESP) begin
      req_ready_s = rsp_ready;
    end else begin
      req_ready_s = ready_r;
    end
`endif
    accept_s = req_valid & req_ready_s;
  end

  // Next-state decode for the issue/capture/response sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE:   state_s = CAPTURE;
      CAPTURE: state_s = RESP;
      RESP: begin
        if (rsp_ready) begin
`ifdef ALU_SEQ_PIPE_EN
          if (accept_s) begin
            state_s = ISSUE;
          end else begin
            state_s = IDLE;
          end
`else
          state_s = IDLE;
`endif
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // One-hot unit enable, only ever raised in ISSUE.
  always_comb begin
    en_s = 4'b0000;
    if (state_r == ISSUE) begin
      case (unit_r)
        UNIT_ARITH: en_s = 4'b0001;
        UNIT_LOGIC: en_s = 4'b0010;
        UNIT_CMP:   en_s = 4'b0100;
        UNIT_SHIFT: en_s = 4'b1000;
        default:    en_s = 4'b0000;
      endcase
    end else begin
      en_s = 4'b0000;
    end
  end

  // Result and flag selection from the unit that was issued.
  always_comb begin
    sel_flag_s = 1'b0;
    sel_out_s  = {OUT_WIDTH{1'b0}};
    case (unit_r)
      UNIT_ARITH: begin sel_flag_s = arith_flag; sel_out_s = arith_out; end
      UNIT_LOGIC: begin sel_flag_s = logic_flag; sel_out_s = logic_out; end
      UNIT_CMP:   begin sel_flag_s = cmp_flag;   sel_out_s = cmp_out;   end
      UNIT_SHIFT: begin sel_flag_s = shift_flag; sel_out_s = shift_out; end
      default:    begin sel_flag_s = 1'b0;       sel_out_s = {OUT_WIDTH{1'b0}}; end
    endcase
  end

  // State register plus registered ready.
  always_ff @(posedge clk or negedge rst_seq) begin
    if (!rst_seq) begin
      state_r <= IDLE;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == IDLE);
    end
  end

  // Operand and sub-function capture on request accept; held until the next accept.
  always_ff @(posedge clk or negedge rst_seq) begin
    if (!rst_seq) begin
      a_r    <= {OPERAND_WIDTH{1'b0}};
      b_r    <= {OPERAND_WIDTH{1'b0}};
      fun_r  <= 2'b00;
      unit_r <= 2'b00;
    end else if (accept_s) begin
      a_r    <= req_a;
      b_r    <= req_b;
      fun_r  <= req_fun[1:0];
      unit_r <= req_fun[3:2];
    end
  end

  // Response capture: flag leaving ISSUE, data leaving CAPTURE, cleared valid on handshake.
  always_ff @(posedge clk or negedge rst_seq) begin
    if (!rst_seq) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {OUT_WIDTH{1'b0}};
      rsp_flag_r  <= 1'b0;
      rsp_unit_r  <= 2'b00;
    end else begin
      if (state_r == ISSUE) begin
        rsp_flag_r <= sel_flag_s;
      end
      if (state_r == CAPTURE) begin
        rsp_data_r  <= sel_out_s;
        rsp_unit_r  <= unit_r;
        rsp_valid_r <= 1'b1;
      end else if ((state_r == RESP) && rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

  assign req_ready    = req_ready_s;
  assign a_unit       = a_r;
  assign b_unit       = b_r;
  assign fun_unit     = fun_r;
  assign arith_enable = en_s[0];
  assign logic_enable = en_s[1];
  assign cmp_enable   = en_s[2];
  assign shift_enable = en_s[3];
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_flag     = rsp_flag_r;
  assign rsp_unit     = rsp_unit_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with behavioural ALU units that register their result on enable.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_PIPE_EN
  localparam int SPACING = 3;
`else
  localparam int SPACING = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_seq;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a, req_b;
  logic [3:0]  req_fun;
  logic [15:0] a_unit, b_unit;
  logic [1:0]  fun_unit;
  logic        arith_enable, logic_enable, cmp_enable, shift_enable;
  logic [15:0] arith_out = 16'h0000;
  logic [15:0] logic_out = 16'h0000;
  logic [15:0] cmp_out   = 16'h0000;
  logic [15:0] shift_out = 16'h0000;
  logic        arith_flag, logic_flag, cmp_flag, shift_flag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_flag;
  logic [1:0]  rsp_unit;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ovl_errs = 0;
  int en_cnt [4];
  int pulse_q [$];
  logic [15:0] rsp_q [$];
  wire [3:0] en_vec = {shift_enable, cmp_enable, logic_enable, arith_enable};

  alu_op_sequencer dut (
    .clk(clk), .rst_seq(rst_seq),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_fun(req_fun),
    .a_unit(a_unit), .b_unit(b_unit), .fun_unit(fun_unit),
    .arith_enable(arith_enable), .logic_enable(logic_enable),
    .cmp_enable(cmp_enable), .shift_enable(shift_enable),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_unit(rsp_unit)
  );

  always #5 clk = ~clk;

  // Behavioural unit functions; flag = result is nonzero, only while enabled.
  function automatic logic [15:0] unit_fn(input logic [1:0] u, input logic [1:0] s,
                                          input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case ({u, s})
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a + 16'd1;
      4'b0011: r = a - 16'd1;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = a ^ b;
      4'b0111: r = ~a;
      4'b1000: r = {15'd0, a == b};
      4'b1001: r = {15'd0, a < b};
      4'b1010: r = {15'd0, a > b};
      4'b1011: r = {15'd0, a != b};
      4'b1100: r = a >> 1;
      4'b1101: r = a << 1;
      4'b1110: r = a >> b[3:0];
      default: r = a << b[3:0];
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (arith_enable) arith_out <= unit_fn(2'b00, fun_unit, a_unit, b_unit);
    if (logic_enable) logic_out <= unit_fn(2'b01, fun_unit, a_unit, b_unit);
    if (cmp_enable)   cmp_out   <= unit_fn(2'b10, fun_unit, a_unit, b_unit);
    if (shift_enable) shift_out <= unit_fn(2'b11, fun_unit, a_unit, b_unit);
  end

  assign arith_flag = arith_enable && (unit_fn(2'b00, fun_unit, a_unit, b_unit) != 16'h0000);
  assign logic_flag = logic_enable && (unit_fn(2'b01, fun_unit, a_unit, b_unit) != 16'h0000);
  assign cmp_flag   = cmp_enable   && (unit_fn(2'b10, fun_unit, a_unit, b_unit) != 16'h0000);
  assign shift_flag = shift_enable && (unit_fn(2'b11, fun_unit, a_unit, b_unit) != 16'h0000);

  // Monitor: enable pulse log, per-unit pulse counts, overlap count, retired responses.
  always @(negedge clk) begin
    if (en_vec != 4'b0000) pulse_q.push_back(cyc);
    if ($countones(en_vec) > 1) ovl_errs++;
    for (int i = 0; i < 4; i++) if (en_vec[i]) en_cnt[i]++;
    if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
  end

  // Present a request at a negedge and return at the negedge after it is accepted.
  task automatic issue_req(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                           output bit ok);
    req_a = a; req_b = b; req_fun = f; req_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic clear_logs();
    pulse_q.delete();
    rsp_q.delete();
    for (int i = 0; i < 4; i++) en_cnt[i] = 0;
  endtask

  task automatic test_reset();
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b exp 0", req_ready); end
    n_checks++; if (en_vec !== 4'b0000) begin n_fail++; $display("FAIL rst_en: got %b exp 0000", en_vec); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", rsp_valid); end
    n_checks++; if ({rsp_data, rsp_flag, rsp_unit} !== 19'd0) begin n_fail++; $display("FAIL rst_rsp: got %h/%b/%b exp 0", rsp_data, rsp_flag, rsp_unit); end
    n_checks++; if ({a_unit, b_unit, fun_unit} !== 34'd0) begin n_fail++; $display("FAIL rst_opnd: got %h/%h/%b exp 0", a_unit, b_unit, fun_unit); end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    issue_req(16'h0003, 16'h0000, 4'b1101, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL t1_accept: got timeout exp accept"); end
    n_checks++; if (en_vec !== 4'b1000) begin n_fail++; $display("FAIL t1_enable: got %b exp 1000", en_vec); end
    n_checks++; if (fun_unit !== 2'b01) begin n_fail++; $display("FAIL t1_fun_unit: got %b exp 01", fun_unit); end
    n_checks++; if (a_unit !== 16'h0003) begin n_fail++; $display("FAIL t1_a_unit: got %h exp 0003", a_unit); end
    @(negedge clk);
    n_checks++; if (en_vec !== 4'b0000) begin n_fail++; $display("FAIL t1_en_off: got %b exp 0000", en_vec); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_early_valid: got %b exp 0", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid: got %b exp 1", rsp_valid); end
    n_checks++; if (rsp_data !== 16'h0006) begin n_fail++; $display("FAIL t1_data: got %h exp 0006", rsp_data); end
    n_checks++; if (rsp_unit !== 2'b11) begin n_fail++; $display("FAIL t1_unit: got %b exp 11", rsp_unit); end
    n_checks++; if (rsp_flag !== 1'b1) begin n_fail++; $display("FAIL t1_flag: got %b exp 1", rsp_flag); end
  endtask

  task automatic test_hold();
    req_a = 16'h1111; req_b = 16'h2222; req_fun = 4'b0000; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b exp 1", i, rsp_valid); end
      n_checks++; if (rsp_data !== 16'h0006) begin n_fail++; $display("FAIL hold_data[%0d]: got %h exp 0006", i, rsp_data); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b exp 0", i, req_ready); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_retire: got %b exp 0", rsp_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_idle_ready: got %b exp 1", req_ready); end
    n_checks++; if (en_cnt[0] + en_cnt[3] !== 1) begin n_fail++; $display("FAIL hold_ignored: got %0d pulses exp 1", en_cnt[0] + en_cnt[3]); end
  endtask

  task automatic test_sweep();
    logic [15:0] ta [16] = '{16'h0003, 16'h0005, 16'hFFFF, 16'h0000, 16'h00F0, 16'h00F0, 16'hAAAA, 16'h1234,
                             16'h0007, 16'h0007, 16'h0007, 16'h0007, 16'h8001, 16'h0003, 16'h8000, 16'h1000};
    logic [15:0] tb [16] = '{16'h0001, 16'h0005, 16'h0000, 16'h0000, 16'h0F0F, 16'h0F0F, 16'hAAAA, 16'h0000,
                             16'h0007, 16'h0008, 16'h0008, 16'h0007, 16'h0000, 16'h0000, 16'h000F, 16'h0004};
    logic [15:0] td [16] = '{16'h0004, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0FFF, 16'h0000, 16'hEDCB,
                             16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h4000, 16'h0006, 16'h0001, 16'h0000};
    logic        tf [16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                             1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit ok;
    logic [3:0] code;
    logic [3:0] exp_en;
    clear_logs();
    for (int k = 0; k < 16; k++) begin
      code = 4'(k);
      exp_en = 4'b0001 << code[3:2];
      issue_req(ta[k], tb[k], code, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sw_accept[%0d]: got timeout exp accept", k); end
      n_checks++; if (en_vec !== exp_en) begin n_fail++; $display("FAIL sw_enable[%0d]: got %b exp %b", k, en_vec, exp_en); end
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL sw_valid[%0d]: got %b exp 1", k, rsp_valid); end
      n_checks++; if (rsp_data !== td[k]) begin n_fail++; $display("FAIL sw_data[%0d]: got %h exp %h", k, rsp_data, td[k]); end
      n_checks++; if (rsp_flag !== tf[k]) begin n_fail++; $display("FAIL sw_flag[%0d]: got %b exp %b", k, rsp_flag, tf[k]); end
      n_checks++; if (rsp_unit !== code[3:2]) begin n_fail++; $display("FAIL sw_unit[%0d]: got %b exp %b", k, rsp_unit, code[3:2]); end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (en_cnt[i] !== 4) begin n_fail++; $display("FAIL sw_pulses[%0d]: got %0d exp 4", i, en_cnt[i]); end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    bit seen;
    for (int phase = 0; phase < 2; phase++) begin
      issue_req(16'h0101, 16'h0010, 4'b0101, ok);
      if (phase == 1) begin
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid: got %b exp 1", rsp_valid); end
      end
      #2 rst_seq = 1'b0;
      #1;
      n_checks++; if ({req_ready, en_vec, rsp_valid} !== 6'd0) begin n_fail++; $display("FAIL ar_ctrl[%0d]: got %b/%b/%b exp 0", phase, req_ready, en_vec, rsp_valid); end
      n_checks++; if ({rsp_data, rsp_flag, rsp_unit, a_unit, b_unit, fun_unit} !== 53'd0) begin n_fail++; $display("FAIL ar_data[%0d]: got %h/%h/%h exp 0", phase, rsp_data, a_unit, b_unit); end
      @(negedge clk);
      rst_seq = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL ar_dropped[%0d]: got response exp none", phase); end
    end
    issue_req(16'h0003, 16'h0001, 4'b0000, ok);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if ({ok, rsp_valid} !== 2'b11) begin n_fail++; $display("FAIL ar_recover_valid: got %b%b exp 11", ok, rsp_valid); end
    n_checks++; if (rsp_data !== 16'h0004) begin n_fail++; $display("FAIL ar_recover_data: got %h exp 0004", rsp_data); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] sa [3] = '{16'h0003, 16'h00F0, 16'h0003};
    logic [15:0] sb [3] = '{16'h0001, 16'h0F0F, 16'h0000};
    logic [3:0]  sf [3] = '{4'b0000, 4'b0101, 4'b1101};
    logic [15:0] sd [3] = '{16'h0004, 16'h0FFF, 16'h0006};
    int idx = 0;
    bit acc;
    @(negedge clk);
    clear_logs();
    rsp_ready = 1'b1;
    req_a = sa[0]; req_b = sb[0]; req_fun = sf[0]; req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc = req_valid && req_ready;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) begin
          req_a = sa[idx]; req_b = sb[idx]; req_fun = sf[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (idx >= 3 && rsp_q.size() >= 3) break;
    end
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_checks++; if (rsp_q.size() !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d exp 3", rsp_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= rsp_q.size()) begin n_fail++; $display("FAIL b2b_data[%0d]: got none exp %h", i, sd[i]); end
      else if (rsp_q[i] !== sd[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h exp %h", i, rsp_q[i], sd[i]); end
    end
    n_checks++; if (pulse_q.size() !== 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d exp 3", pulse_q.size()); end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (i >= pulse_q.size()) begin n_fail++; $display("FAIL b2b_gap[%0d]: got none exp %0d", i, SPACING); end
      else if (pulse_q[i] - pulse_q[i-1] !== SPACING) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d exp %0d", i, pulse_q[i] - pulse_q[i-1], SPACING); end
    end
  endtask

  initial begin
    rst_seq = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = 16'h0000; req_b = 16'h0000; req_fun = 4'b0000;
    repeat (2) @(negedge clk);
    test_reset();
    rst_seq = 1'b1;
    @(negedge clk);
    test_single();
    test_hold();
    test_sweep();
    test_async_reset();
    test_back_to_back();
    n_checks++; if (ovl_errs !== 0) begin n_fail++; $display("FAIL enable_overlap: got %0d cycles exp 0", ovl_errs); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
